// File: rtl/fp_acc_seq_pkg.sv
// fp_acc_seq_pkg -- accumulator FSM states, float32 field positions and a leading-zero helper.
// Revision 1.0
`default_nettype none

package fp_acc_seq_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_ADD   = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_MSB = 22;

  // Leading zeros of a 24-bit magnitude; an all-zero input reports 24.
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    lzc24 = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) lzc24 = 5'(23 - i);
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_acc_seq_fp_add.sv
// fp_add -- combinational float32 adder, hidden-1 operands, truncating, no special values.
// Revision 1.0
`default_nettype none

module fp_add
  import fp_acc_seq_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  logic        w_a_big;
  logic [31:0] w_big;
  logic [31:0] w_sml;
  logic [23:0] w_m_big;
  logic [23:0] w_m_sml;
  logic [7:0]  w_exp_d;
  logic [23:0] w_m_al;
  logic [24:0] w_m_sum;
  logic [23:0] w_m_diff;
  logic [4:0]  w_lz;
  logic [23:0] w_m_norm;
  logic [7:0]  w_e_big;

  // Order by magnitude so the subtract path never goes negative.
  assign w_a_big  = a[EXP_MSB:0] >= b[EXP_MSB:0];
  assign w_big    = w_a_big ? a : b;
  assign w_sml    = w_a_big ? b : a;
  assign w_e_big  = w_big[EXP_MSB:EXP_LSB];
  assign w_m_big  = {1'b1, w_big[MANT_MSB:0]};
  assign w_m_sml  = {1'b1, w_sml[MANT_MSB:0]};
  assign w_exp_d  = w_e_big - w_sml[EXP_MSB:EXP_LSB];
  assign w_m_al   = (w_exp_d > 8'd23) ? 24'd0 : (w_m_sml >> w_exp_d);
  assign w_m_sum  = {1'b0, w_m_big} + {1'b0, w_m_al};
  assign w_m_diff = w_m_big - w_m_al;
  assign w_lz     = lzc24(w_m_diff);
  assign w_m_norm = w_m_diff << w_lz;

  always_comb begin
    sum = FP32_ZERO;
    if (w_big[SIGN_BIT] == w_sml[SIGN_BIT]) begin
      if (w_m_sum[24]) sum = {w_big[SIGN_BIT], w_e_big + 8'd1, w_m_sum[23:1]};
      else             sum = {w_big[SIGN_BIT], w_e_big, w_m_sum[MANT_MSB:0]};
    end else if (w_m_diff != 24'd0) begin
      sum = {w_big[SIGN_BIT], w_e_big - {3'b000, w_lz}, w_m_norm[MANT_MSB:0]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_acc_seq.sv
// fp_acc_seq -- sums N_TERMS float32 terms in arrival order through one shared fp_add.
// Revision 1.0
`default_nettype none

module fp_acc_seq
  import fp_acc_seq_pkg::*;
#(
  parameter int N_TERMS = 9,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  state_t             r_state;
  logic [31:0]        r_acc;
  logic [31:0]        r_op_a;
  logic [31:0]        r_op_b;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        w_sum;
  logic [CNT_W-1:0]   w_cnt_nx;
  logic               w_last;
  logic               w_term_zero;
  logic               w_acc_zero;
  logic               w_bypass;
  logic [31:0]        w_byp_acc;

  fp_add u_fp_add (
    .a   (r_op_a),
    .b   (r_op_b),
    .sum (w_sum)
  );

  assign w_cnt_nx    = r_cnt + 1'b1;
  assign w_last      = (w_cnt_nx == CNT_W'(N_TERMS));
  assign w_term_zero = (in_data[EXP_MSB:EXP_LSB] == 8'd0);
  assign w_acc_zero  = (r_acc[EXP_MSB:EXP_LSB] == 8'd0);
  // Zeros (and denormals) must never reach fp_add: skip zero terms, load over a zero acc.
  assign w_bypass    = w_term_zero || w_acc_zero || (r_cnt == '0);
  assign w_byp_acc   = w_term_zero ? r_acc : in_data;
  assign busy        = (r_cnt != '0) || (r_state != ST_ACCUM);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_ACCUM;
      r_acc     <= FP32_ZERO;
      r_cnt     <= '0;
      r_op_a    <= FP32_ZERO;
      r_op_b    <= FP32_ZERO;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= FP32_ZERO;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (in_valid && in_ready) begin
            if (w_bypass) begin
              r_acc <= w_byp_acc;
              r_cnt <= w_cnt_nx;
              if (w_last) begin
                r_state   <= ST_DONE;
                in_ready  <= 1'b0;
                out_valid <= 1'b1;
                out_data  <= w_byp_acc;
              end
            end else begin
              r_op_a   <= r_acc;
              r_op_b   <= in_data;
              r_state  <= ST_ADD;
              in_ready <= 1'b0;
            end
          end
        end
        ST_ADD: begin
          r_acc <= w_sum;
          r_cnt <= w_cnt_nx;
          if (w_last) begin
            r_state   <= ST_DONE;
            out_valid <= 1'b1;
            out_data  <= w_sum;
          end else begin
            r_state  <= ST_ACCUM;
            in_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_acc     <= FP32_ZERO;
            r_cnt     <= '0;
            r_state   <= ST_ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_ACCUM;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_acc_seq.sv
// tb_fp_acc_seq -- directed and randomized checks of fp_acc_seq against an exact-sum reference.
// Revision 1.0
`default_nettype none

module tb_fp_acc_seq;

  localparam int N = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          rand_or  = 1'b0;
  logic [31:0] exp_q[$];

  fp_acc_seq #(.N_TERMS(N), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, expv);
    end
  endtask

  // Reference: integer terms summed exactly, then converted; exact for |sum| < 2**24.
  function automatic logic [31:0] int_to_fp(input longint v);
    longint      m;
    int          p;
    logic [63:0] mm;
    logic        s;
    if (v == 0) return 32'h0;
    s = (v < 0);
    m = s ? -v : v;
    p = 0;
    for (int i = 0; i < 24; i++) if (m[i]) p = i;
    mm = 64'(m) << (23 - p);
    return {s, 8'(127 + p), mm[22:0]};
  endfunction

  function automatic longint rand_int();
    int     k;
    longint m;
    if ($urandom_range(3) == 0) return 0;
    k = $urandom_range(20);
    m = longint'($urandom_range((1 << k) - 1));
    return ($urandom_range(1) == 1) ? -m : m;
  endfunction

  // Random out_ready, applied off the instants used by the directed code.
  initial forever begin
    @(posedge clk);
    #2;
    if (rand_or) out_ready = ($urandom_range(3) != 0);
  end

  // Every completed output handshake is compared with the oldest expected sum.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check_eq("spurious_out", {31'b0, out_valid}, 32'd0);
      else                   check_eq("sum", out_data, exp_q.pop_front());
    end
  end

  task automatic send_term(input logic [31:0] t, input int gap_pct);
    int guard;
    bit took;
    while ($urandom_range(99) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = t;
    guard    = 0;
    forever begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      if (took) break;
      guard++;
      if (guard > 500) begin
        check_eq("in_timeout", 32'(guard), 32'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_fp(input logic [31:0] t[N], input logic [31:0] expv, input int gap_pct);
    exp_q.push_back(expv);
    for (int i = 0; i < N; i++) send_term(t[i], gap_pct);
  endtask

  task automatic send_ints(input int gap_pct);
    logic [31:0] t[N];
    longint      s;
    s = 0;
    for (int i = 0; i < N; i++) begin
      longint v;
      v    = rand_int();
      s   += v;
      t[i] = int_to_fp(v);
    end
    send_fp(t, int_to_fp(s), gap_pct);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (exp_q.size() != 0) check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [19:0] rdy_v, ov_v, rdy_e, ov_e;
    logic [31:0] t[N];
    logic [31:0] held;
    int          s0, guard;

    rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_out_data",  out_data,           32'h0);
    check_eq("rst_busy",      {31'b0, busy},      32'd0);
    rst = 1'b0;

    // Nine 1.0 with in_valid held high: alternating in_ready while adds run.
    out_ready = 1'b1;
    exp_q.push_back(32'h4110_0000);
    in_valid = 1'b1;
    in_data  = 32'h3F80_0000;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rdy_v[c] = in_ready;
      ov_v[c]  = out_valid;
      rdy_e[c] = (c < 2) || (c >= 3 && c <= 15 && (c % 2 == 1)) || (c >= 18);
      ov_e[c]  = (c == 17);
      if (c == 16) in_valid = 1'b0;
    end
    check_eq("t1_in_ready_seq",  {12'b0, rdy_v}, {12'b0, rdy_e});
    check_eq("t1_out_valid_seq", {12'b0, ov_v},  {12'b0, ov_e});
    @(posedge clk);
    #1;
    wait_drain();

    // 1.0 + 2.0 + 0.5 then zeros: zero terms cost one cycle each.
    t = '{32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    s0 = cyc;
    send_fp(t, 32'h4060_0000, 0);
    check_eq("t2_cycles", 32'(cyc - s0), 32'd11);
    wait_drain();

    // Exact cancellation followed by a bypass load.
    t = '{32'h4040_0000, 32'hC040_0000, 32'h4000_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    send_fp(t, 32'h4000_0000, 0);
    wait_drain();

    // Output stalled in DONE while upstream offers a term.
    out_ready = 1'b0;
    send_ints(0);
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    held     = (exp_q.size() != 0) ? exp_q[0] : 32'h0;
    in_valid = 1'b1;
    in_data  = 32'h3F80_0000;
    repeat (5) begin
      @(negedge clk);
      check_eq("t4_out_valid", {31'b0, out_valid}, 32'd1);
      check_eq("t4_in_ready",  {31'b0, in_ready},  32'd0);
      check_eq("t4_out_data",  out_data,           held);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    send_ints(0);
    wait_drain();

    // Reset part-way through a sum discards it.
    for (int i = 0; i < 4; i++) send_term(32'h3F80_0000, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t5_busy_after_rst",     {31'b0, busy},     32'd0);
    check_eq("t5_in_ready_after_rst", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;
    for (int i = 0; i < N; i++) t[i] = 32'h3F80_0000;
    send_fp(t, 32'h4110_0000, 0);
    wait_drain();

    // Random terms with random gaps on both sides.
    rand_or = 1'b1;
    repeat (12) send_ints(30);
    wait_drain();
    rand_or = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (4) send_ints(10);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
